// File: rtl/count_nox_ctrl.sv
// Scan controller: counts how many of the first LEN memory words equal X,
// driving the load/inc strobes of the external "i" (index) and "tr" (tally) counters.
module count_nox_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [CNT_W-1:0]  len_in,
    output logic              mem_rd,
    output logic [CNT_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [CNT_W-1:0]  i_val,
    input  logic [CNT_W-1:0]  tr_val,
    output logic [CNT_W-1:0]  cnt_init,
    output logic              i_load,
    output logic              i_inc,
    output logic              tr_load,
    output logic              tr_inc,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_xQ;
    logic [CNT_W-1:0]   r_lenQ;
    logic               w_match;
    logic               w_scanEnd;

    assign w_match   = (mem_data == r_xQ);
    assign w_scanEnd = (i_val == r_lenQ);
    assign cnt_init  = '0;

    // Target and length are captured only on acceptance, so later changes
    // on x_in/len_in (or a start while busy) cannot disturb a running scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_xQ    <= '0;
            r_lenQ  <= '0;
            result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xQ    <= x_in;
                        r_lenQ  <= len_in;
                        r_state <= S_INIT;
                    end
                end
                S_INIT:  r_state <= S_CHECK;
                S_CHECK: r_state <= w_scanEnd ? S_DONE : S_WAIT;
                S_WAIT:  r_state <= S_CHECK;
                S_DONE: begin
                    result  <= tr_val;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the current state; the tally increment
    // additionally depends on the word returned during WAIT.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        i_load   = 1'b0;
        i_inc    = 1'b0;
        tr_load  = 1'b0;
        tr_inc   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_INIT: begin
                busy    = 1'b1;
                i_load  = 1'b1;
                tr_load = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (!w_scanEnd) begin
                    mem_rd   = 1'b1;
                    mem_addr = i_val;
                end
            end
            S_WAIT: begin
                busy   = 1'b1;
                i_inc  = 1'b1;
                tr_inc = w_match;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
